round_robin_mux_4_1: RTL and testbench

ROUND_ROBIN_MUX_4_1 -- requirements
Module: round_robin_mux_4_1

---
 rtl/round_robin_mux_4_1.sv | 102 ++++++++++
 tb/tb_round_robin_mux_4_1.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/round_robin_mux_4_1.sv
// Four-channel round-robin multiplexer with a registered, ready/valid output stage.
// Optional ROUND_ROBIN_MUX_4_1_CH0_PRIORITY_EN gives channel 0 absolute priority.
module round_robin_mux_4_1 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel
);

  logic [1:0]       ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_sel_q, out_sel_d;

  logic             load;
  logic             any_valid;
  logic             accept;
  logic [1:0]       gnt;
  logic [1:0]       idx;
  logic             found;
  logic [WIDTH-1:0] sel_data;

  // Search ptr, ptr+1, ptr+2, ptr+3; the 2-bit index wraps naturally.
  always_comb begin
    gnt   = ptr_q;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && in_valid[idx]) begin
        gnt   = idx;
        found = 1'b1;
      end
    end
`ifdef ROUND_ROBIN_MUX_4_1_CH0_PRIORITY_EN
    if (in_valid[0]) begin
      gnt = 2'd0;
    end
`endif
  end

  assign any_valid = |in_valid;
  assign load      = !out_valid_q || out_ready;
  assign accept    = !rst && load && any_valid;
  assign in_ready  = accept ? (4'b0001 << gnt) : 4'b0000;

  // Only the granted channel reaches the register, so other channels' data is don't-care.
  always_comb begin
    sel_data = d0;
    case (gnt)
      2'd0: sel_data = d0;
      2'd1: sel_data = d1;
      2'd2: sel_data = d2;
      2'd3: sel_data = d3;
      default: sel_data = d0;
    endcase
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (accept) begin
      ptr_d       = gnt + 2'd1;
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_sel_d   = gnt;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_round_robin_mux_4_1.sv
// Self-checking bench for round_robin_mux_4_1: directed scenarios plus random traffic
// compared against a transaction-level reference model.
module tb_round_robin_mux_4_1;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       in_valid;
  logic [3:0]       in_ready;
  logic [WIDTH-1:0] d0, d1, d2, d3;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int               m_ptr;
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_sel;

  round_robin_mux_4_1 #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .d0       (d0),
    .d1       (d1),
    .d2       (d2),
    .d3       (d3),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sel  (out_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    int g;
    g = -1;
`ifdef ROUND_ROBIN_MUX_4_1_CH0_PRIORITY_EN
    if (in_valid[0]) return 0;
`endif
    for (int k = 0; k < 4; k++) begin
      if (g < 0 && in_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    end
    return g;
  endfunction

  function automatic logic [WIDTH-1:0] chan_data(input int c);
    case (c)
      0: return d0;
      1: return d1;
      2: return d2;
      default: return d3;
    endcase
  endfunction

  // One clock: check combinational ready, clock, advance model, check registers.
  task automatic step(input string tag);
    int         g;
    bit         take;
    logic [3:0] exp_rdy;
    #1;
    g       = model_grant();
    take    = !rst && (!m_valid || out_ready) && (g >= 0);
    exp_rdy = take ? 4'(1 << g) : 4'b0000;
    chk({tag, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
    chk({tag, " in_ready onehot0"}, 32'($onehot0(in_ready)), 32'd1);
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0;
    end else if (take) begin
      m_valid = 1; m_data = chan_data(g); m_sel = g; m_ptr = (g + 1) % 4;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    #1;
    chk({tag, " out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, " out_data"}, 32'(out_data), 32'(m_data));
    chk({tag, " out_sel"}, 32'(out_sel), 32'(m_sel));
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 4'b1111; out_ready = 1;
    step("reset0");
    step("reset1");
    rst = 0;
  endtask

  initial begin
    m_ptr = 0; m_valid = 0; m_data = '0; m_sel = 0;
    rst = 1; in_valid = 4'b1111; out_ready = 1;
    d0 = 4'ha; d1 = 4'hb; d2 = 4'hc; d3 = 4'hd;
    @(negedge clk);

    // Reset with all channels requesting
    do_reset();
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset out_sel", 32'(out_sel), 32'd0);

`ifndef ROUND_ROBIN_MUX_4_1_CH0_PRIORITY_EN
    // Fairness: a,b,c,d repeating
    in_valid = 4'b1111; out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      step("fair");
      chk("fair sel seq", 32'(out_sel), 32'(i % 4));
      chk("fair data seq", 32'(out_data), 32'(4'ha + 4'(i % 4)));
    end

    // Skip and wrap: 1,3,1
    do_reset();
    in_valid = 4'b1010;
    step("skip0"); chk("skip sel0", 32'(out_sel), 32'd1);
    step("skip1"); chk("skip sel1", 32'(out_sel), 32'd3);
    step("skip2"); chk("skip sel2", 32'(out_sel), 32'd1);

    // Backpressure holding 7 from channel 0
    do_reset();
    d0 = 4'h7; in_valid = 4'b0001;
    step("bp load"); chk("bp data7", 32'(out_data), 32'h7);
    in_valid = 4'b1111; out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step("bp hold");
      chk("bp hold data", 32'(out_data), 32'h7);
      chk("bp hold sel", 32'(out_sel), 32'd0);
    end
    out_ready = 1;
    step("bp release"); chk("bp next sel", 32'(out_sel), 32'd1);

    // X isolation on channel 3
    do_reset();
    d0 = 4'h0; d1 = 4'h1; d2 = 4'h2; d3 = 'x; in_valid = 4'b0111;
    for (int i = 0; i < 6; i++) begin
      step("xiso");
      chk("xiso no X", 32'($isunknown(out_data)), 32'd0);
      chk("xiso seq", 32'(out_data), 32'(i % 3));
    end
    d3 = 4'hd;

    // Idle cycles must not advance ptr
    do_reset();
    in_valid = 4'b0010; step("idle a");
    in_valid = 4'b0000; step("idle b"); step("idle c");
    in_valid = 4'b1111; step("idle d");
    chk("idle ptr kept", 32'(out_sel), 32'd2);
`else
    // Channel 0 starves the others, then round-robin resumes among 1..3
    do_reset();
    in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step("prio");
      chk("prio sel0", 32'(out_sel), 32'd0);
    end
    in_valid = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      step("prio rr");
      chk("prio rr seq", 32'(out_sel), 32'(i + 1));
    end
`endif

    // Random traffic with occasional mid-stream reset
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      d0 = 4'($urandom); d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
